// File: rtl/mem_arbiter.sv
// Round-robin arbiter that lets two requesters share one line-wide memory port.
// Each grant covers one whole transaction, and a watchdog aborts a transaction whose ack never arrives.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 256,
  parameter int TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p0_req_i,
  input  logic              p0_write_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [DATA_W-1:0] p0_data_i,
  output logic              p0_ack_o,
  output logic [DATA_W-1:0] p0_data_o,
  input  logic              p1_req_i,
  input  logic              p1_write_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_data_i,
  output logic              p1_ack_o,
  output logic [DATA_W-1:0] p1_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              err_o
);

  localparam int WDOG_W = $clog2(TIMEOUT);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              r_prio;
  logic              r_owner;
  logic              r_mem_en;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_data;
  logic [WDOG_W-1:0] r_wdog;
  logic              r_p0_ack;
  logic              r_p1_ack;
  logic [DATA_W-1:0] r_p0_data;
  logic [DATA_W-1:0] r_p1_data;
  logic              r_err;
  logic              w_grant;
  logic              w_gnt_port;
  logic              w_finish;
  logic              w_timeout;
  logic [DATA_W-1:0] w_resp_data;

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state, grant selection and completion decode
  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    w_gnt_port   = r_prio;
    w_finish     = 1'b0;
    w_timeout    = 1'b0;
    w_resp_data  = {DATA_W{1'b0}};
    case (r_state)
      ST_IDLE: begin
        if (p0_req_i || p1_req_i) begin
          w_grant      = 1'b1;
          w_next_state = ST_BUSY;
          if (p0_req_i && p1_req_i) begin
            w_gnt_port = r_prio;
          end else if (p1_req_i) begin
            w_gnt_port = 1'b1;
          end else begin
            w_gnt_port = 1'b0;
          end
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // An ack arriving on the last watchdog cycle still completes the transaction normally.
        if (mem_ack_i) begin
          w_finish     = 1'b1;
          w_next_state = ST_DONE;
          if (r_mem_write) begin
            w_resp_data = {DATA_W{1'b0}};
          end else begin
            w_resp_data = mem_data_i;
          end
        end else if (r_wdog == WDOG_LAST) begin
          w_finish     = 1'b1;
          w_timeout    = 1'b1;
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_BUSY;
        end
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Latched transaction, watchdog, per-port responses and the sticky error flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_prio      <= 1'b1;
      r_owner     <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= {ADDR_W{1'b0}};
      r_mem_data  <= {DATA_W{1'b0}};
      r_wdog      <= {WDOG_W{1'b0}};
      r_p0_ack    <= 1'b0;
      r_p1_ack    <= 1'b0;
      r_p0_data   <= {DATA_W{1'b0}};
      r_p1_data   <= {DATA_W{1'b0}};
      r_err       <= 1'b0;
    end else begin
      r_p0_ack  <= 1'b0;
      r_p1_ack  <= 1'b0;
      r_p0_data <= {DATA_W{1'b0}};
      r_p1_data <= {DATA_W{1'b0}};
      if (w_grant) begin
        r_owner  <= w_gnt_port;
        r_prio   <= ~w_gnt_port;
        r_mem_en <= 1'b1;
        r_wdog   <= {WDOG_W{1'b0}};
        if (w_gnt_port) begin
          r_mem_write <= p1_write_i;
          r_mem_addr  <= p1_addr_i;
          r_mem_data  <= p1_data_i;
        end else begin
          r_mem_write <= p0_write_i;
          r_mem_addr  <= p0_addr_i;
          r_mem_data  <= p0_data_i;
        end
      end else if (w_finish) begin
        r_mem_en    <= 1'b0;
        r_mem_write <= 1'b0;
        r_mem_addr  <= {ADDR_W{1'b0}};
        r_mem_data  <= {DATA_W{1'b0}};
        r_wdog      <= {WDOG_W{1'b0}};
        r_p0_ack    <= ~r_owner;
        r_p1_ack    <= r_owner;
        r_p0_data   <= r_owner ? {DATA_W{1'b0}} : w_resp_data;
        r_p1_data   <= r_owner ? w_resp_data : {DATA_W{1'b0}};
        if (w_timeout) begin
          r_err <= 1'b1;
        end
      end else if (r_state == ST_BUSY) begin
        r_wdog <= r_wdog + WDOG_W'(1);
      end
    end
  end

  assign mem_enable_o = r_mem_en;
  assign mem_write_o  = r_mem_write;
  assign mem_addr_o   = r_mem_addr;
  assign mem_data_o   = r_mem_data;
  assign p0_ack_o     = r_p0_ack;
  assign p1_ack_o     = r_p1_ack;
  assign p0_data_o    = r_p0_data;
  assign p1_data_o    = r_p1_data;
  assign err_o        = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: reset, arbitration order, write stability,
// watchdog abort and ack-wins boundary, reset mid-transaction, and stray memory acks.
module tb_mem_arbiter;

  localparam logic [255:0] D_RD1  = {8{32'hCAFE_0001}};
  localparam logic [255:0] D_RD2  = {8{32'h1234_5678}};
  localparam logic [255:0] D_WR   = {{31{8'hAA}}, 8'hA5};
  localparam logic [255:0] D_ZERO = 256'd0;

  logic         clk_i;
  logic         rst_i;
  logic         p0_req_i, p0_write_i, p0_ack_o;
  logic [31:0]  p0_addr_i;
  logic [255:0] p0_data_i, p0_data_o;
  logic         p1_req_i, p1_write_i, p1_ack_o;
  logic [31:0]  p1_addr_i;
  logic [255:0] p1_data_i, p1_data_o;
  logic         mem_enable_o, mem_write_o, mem_ack_i, err_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o, mem_data_i;

  int n_checks = 0;
  int n_errors = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(256), .TIMEOUT(64)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .p0_req_i(p0_req_i), .p0_write_i(p0_write_i), .p0_addr_i(p0_addr_i),
    .p0_data_i(p0_data_i), .p0_ack_o(p0_ack_o), .p0_data_o(p0_data_o),
    .p1_req_i(p1_req_i), .p1_write_i(p1_write_i), .p1_addr_i(p1_addr_i),
    .p1_data_i(p1_data_i), .p1_ack_o(p1_ack_o), .p1_data_o(p1_data_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
    .err_o(err_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag, input logic exp_err);
    chk({tag, "_en"},    {255'd0, mem_enable_o}, {255'd0, 1'b0});
    chk({tag, "_wr"},    {255'd0, mem_write_o},  {255'd0, 1'b0});
    chk({tag, "_addr"},  {224'd0, mem_addr_o},   D_ZERO);
    chk({tag, "_mdata"}, mem_data_o,             D_ZERO);
    chk({tag, "_ack0"},  {255'd0, p0_ack_o},     {255'd0, 1'b0});
    chk({tag, "_ack1"},  {255'd0, p1_ack_o},     {255'd0, 1'b0});
    chk({tag, "_dat0"},  p0_data_o,              D_ZERO);
    chk({tag, "_dat1"},  p1_data_o,              D_ZERO);
    chk({tag, "_err"},   {255'd0, err_o},        {255'd0, exp_err});
  endtask

  // Starts at a sample point in IDLE with the owner's request already driven; ends at the DONE sample.
  task automatic txn(input string tag, input logic owner, input logic [31:0] addr,
                     input logic wr, input logic [255:0] wdata, input int nbusy,
                     input logic ack_it, input logic [255:0] rdata, input logic mutate,
                     input logic err_busy, input logic err_done);
    logic [255:0] resp;
    resp = (ack_it && !wr) ? rdata : D_ZERO;
    for (int i = 0; i < nbusy; i++) begin
      tick();
      chk({tag, "_busy_en"},    {255'd0, mem_enable_o}, {255'd0, 1'b1});
      chk({tag, "_busy_wr"},    {255'd0, mem_write_o},  {255'd0, wr});
      chk({tag, "_busy_addr"},  {224'd0, mem_addr_o},   {224'd0, addr});
      chk({tag, "_busy_mdata"}, mem_data_o,             wdata);
      chk({tag, "_busy_ack0"},  {255'd0, p0_ack_o},     {255'd0, 1'b0});
      chk({tag, "_busy_ack1"},  {255'd0, p1_ack_o},     {255'd0, 1'b0});
      chk({tag, "_busy_err"},   {255'd0, err_o},        {255'd0, err_busy});
      if (mutate && i == 0) begin
        if (owner) begin
          p1_addr_i = 32'h0000_0BAD; p1_data_i = ~wdata; p1_write_i = ~wr; p1_req_i = 1'b0;
        end else begin
          p0_addr_i = 32'h0000_0BAD; p0_data_i = ~wdata; p0_write_i = ~wr; p0_req_i = 1'b0;
        end
      end
      if (ack_it && i == nbusy - 1) begin
        mem_ack_i  = 1'b1;
        mem_data_i = rdata;
      end
    end
    tick();
    mem_ack_i  = 1'b0;
    mem_data_i = D_ZERO;
    chk({tag, "_done_en"},   {255'd0, mem_enable_o}, {255'd0, 1'b0});
    chk({tag, "_done_ack0"}, {255'd0, p0_ack_o},     {255'd0, ~owner});
    chk({tag, "_done_ack1"}, {255'd0, p1_ack_o},     {255'd0, owner});
    chk({tag, "_done_dat0"}, p0_data_o,              owner ? D_ZERO : resp);
    chk({tag, "_done_dat1"}, p1_data_o,              owner ? resp : D_ZERO);
    chk({tag, "_done_err"},  {255'd0, err_o},        {255'd0, err_done});
  endtask

  initial begin
    logic exp_owner [4];
    exp_owner = '{1'b1, 1'b0, 1'b1, 1'b0};
    rst_i = 1'b1;
    p0_req_i = 1'b0; p0_write_i = 1'b0; p0_addr_i = 32'd0; p0_data_i = D_ZERO;
    p1_req_i = 1'b0; p1_write_i = 1'b0; p1_addr_i = 32'd0; p1_data_i = D_ZERO;
    mem_ack_i = 1'b0; mem_data_i = D_ZERO;
    tick();
    tick();
    chk_quiet("reset", 1'b0);

    // Single port-0 read, memory acks on the fifth enable cycle
    rst_i = 1'b0;
    p0_req_i = 1'b1; p0_addr_i = 32'h0000_0100;
    txn("t1_p0_read", 1'b0, 32'h0000_0100, 1'b0, D_ZERO, 5, 1'b1, D_RD1, 1'b0, 1'b0, 1'b0);
    p0_req_i = 1'b0;
    tick();
    chk_quiet("t1_idle", 1'b0);

    // Both held: port 1 first, then strict alternation
    p0_req_i = 1'b1; p0_addr_i = 32'h0000_0200;
    p1_req_i = 1'b1; p1_addr_i = 32'h0000_0300;
    for (int k = 0; k < 4; k++) begin
      txn($sformatf("t2_rr%0d", k), exp_owner[k],
          exp_owner[k] ? 32'h0000_0300 : 32'h0000_0200, 1'b0, D_ZERO, 2, 1'b1,
          exp_owner[k] ? D_RD2 : D_RD1, 1'b0, 1'b0, 1'b0);
      if (k == 3) begin
        p0_req_i = 1'b0; p1_req_i = 1'b0;
      end
      tick();
      chk_quiet($sformatf("t2_idle%0d", k), 1'b0);
    end

    // Port-1 write; requester scrambles fields and drops req during BUSY
    p1_req_i = 1'b1; p1_write_i = 1'b1; p1_addr_i = 32'h0000_0400; p1_data_i = D_WR;
    txn("t3_p1_write", 1'b1, 32'h0000_0400, 1'b1, D_WR, 3, 1'b1, D_RD2, 1'b1, 1'b0, 1'b0);
    p1_write_i = 1'b0; p1_data_i = D_ZERO;
    tick();
    chk_quiet("t3_idle", 1'b0);

    // Ack on the 64th BUSY cycle beats the watchdog
    p0_req_i = 1'b1; p0_write_i = 1'b0; p0_addr_i = 32'h0000_0480; p0_data_i = D_ZERO;
    txn("t3b_ack_at_limit", 1'b0, 32'h0000_0480, 1'b0, D_ZERO, 64, 1'b1, D_RD1, 1'b0, 1'b0, 1'b0);
    p0_req_i = 1'b0;
    tick();
    chk_quiet("t3b_idle", 1'b0);

    // No ack: watchdog aborts after 64 BUSY cycles, then normal service resumes
    p0_req_i = 1'b1; p0_addr_i = 32'h0000_0500;
    txn("t4_timeout", 1'b0, 32'h0000_0500, 1'b0, D_ZERO, 64, 1'b0, D_ZERO, 1'b0, 1'b0, 1'b1);
    p0_req_i = 1'b0;
    tick();
    chk_quiet("t4_idle", 1'b1);
    p1_req_i = 1'b1; p1_addr_i = 32'h0000_0600;
    txn("t4_after", 1'b1, 32'h0000_0600, 1'b0, D_ZERO, 2, 1'b1, D_RD2, 1'b0, 1'b1, 1'b1);
    p1_req_i = 1'b0;
    tick();
    chk_quiet("t4_idle2", 1'b1);

    // Reset mid-BUSY, then a late memory ack that must be ignored
    p0_req_i = 1'b1; p0_addr_i = 32'h0000_0700;
    tick();
    chk("t5_busy_en", {255'd0, mem_enable_o}, {255'd0, 1'b1});
    tick();
    rst_i = 1'b1;
    tick();
    chk_quiet("t5_reset", 1'b0);
    rst_i = 1'b0; p0_req_i = 1'b0;
    mem_ack_i = 1'b1; mem_data_i = D_RD1;
    tick();
    mem_ack_i = 1'b0; mem_data_i = D_ZERO;
    chk_quiet("t5_late_ack", 1'b0);
    tick();
    chk_quiet("t5_after", 1'b0);

    // Stray ack in IDLE, then a minimum-latency transaction proves IDLE was kept
    mem_ack_i = 1'b1; mem_data_i = D_RD2;
    tick();
    mem_ack_i = 1'b0; mem_data_i = D_ZERO;
    chk_quiet("t6_stray", 1'b0);
    tick();
    chk_quiet("t6_stray2", 1'b0);
    p1_req_i = 1'b1; p1_addr_i = 32'h0000_0800;
    txn("t6_minlat", 1'b1, 32'h0000_0800, 1'b0, D_ZERO, 1, 1'b1, D_RD1, 1'b0, 1'b0, 1'b0);
    p1_req_i = 1'b0;
    tick();
    chk_quiet("t6_idle", 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
